mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage issue strobe for md_op.
REQ-006 SHALL have port md_op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
REQ-007 SHALL have port rs_data  input  32  forwarded rs operand.
REQ-008 SHALL have port rt_data  input  32  forwarded rt operand.
REQ-009 SHALL have port d_mden  input  1  D-stage instruction uses the MDU.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port stall  output  1  freeze D stage.
REQ-012 SHALL have port md_rdata  output  32  mfhi/mflo read result.
REQ-013 SHALL have port hi  output  32  HI register.
REQ-014 SHALL have port lo  output  32  LO register.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV; busy = (state != IDLE).
REQ-016 IDLE with start and md_op 1/2 SHALL latch operands, load counter with MULT_CYCLES, go to MUL.
REQ-017 IDLE with start and md_op 3/4 SHALL latch operands, load counter with DIV_CYCLES, go to DIV.
REQ-018 In MUL/DIV the counter SHALL decrement each cycle; at counter==1 the edge SHALL write HI/LO and return to IDLE.
REQ-019 Timing: start sampled in cycle n -> busy high cycles n+1..n+N exactly; new HI/LO visible from cycle n+N+1.
REQ-020 mult/multu SHALL produce a 64-bit signed/unsigned product, HI=[63:32], LO=[31:0].
REQ-021 div/divu SHALL set LO=quotient truncated toward zero, HI=remainder with dividend sign.
REQ-022 Divide by zero SHALL consume DIV_CYCLES and leave HI/LO unchanged.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-024 In IDLE, start with mthi/mtlo SHALL write rs_data to HI/LO at that edge, no busy.
REQ-025 md_rdata SHALL be combinational: HI for md_op 5, LO for md_op 6, else 0.
REQ-026 start while busy SHALL be ignored (state, counter, HI/LO unchanged).
REQ-027 stall SHALL equal d_mden & (busy | (start & md_op in 1..4)).
REQ-028 start with md_op 0 or >8 SHALL have no effect.

Reset
REQ-029 reset low SHALL immediately force state IDLE, counter 0, HI=0, LO=0, latched operands 0.
REQ-030 During reset busy, stall and md_rdata SHALL be 0; hi and lo SHALL read 0.
REQ-031 reset asserted mid-operation SHALL abort it with no HI/LO write; operation resumes only via new start.

Structure
REQ-032 md_op encodings and state encodings SHALL live in the shared CPU package and be used by the decoder as well.
REQ-033 Arithmetic SHALL be in one sub-module mdu_arith (combinational 64-bit product, quotient, remainder from latched operands); mdu_ctrl holds FSM, counter, HI/LO.

Verification
REQ-034 mult 0xFFFFFFFF x 2 (signed) -> busy cycles n+1..n+5, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 div -7 / 2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> 10 busy cycles, HI/LO unchanged.
REQ-036 d_mden=1 (mfhi) throughout a mult -> stall high cycles n..n+5, low at n+6, md_rdata = new HI at n+6.
REQ-037 mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle; mthi issued while busy -> ignored.
REQ-038 reset low in cycle 3 of a div -> busy 0 at once, HI=LO=0, no later write.
REQ-039 div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 after 10 cycles.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared MDU operation and FSM state encodings for the controller and decoder.
package mdu_ctrl_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;
endpackage

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational 64-bit product, quotient and remainder of the latched operands.
module mdu_arith (
  input  logic        sgn_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] prod_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        div0_o
);
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  assign a_neg  = sgn_i & a_i[31];
  assign b_neg  = sgn_i & b_i[31];
  assign prod_o = {{32{a_neg}}, a_i} * {{32{b_neg}}, b_i};
  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign div0_o = b_i == '0;
  assign q_mag  = div0_o ? '0 : a_mag / b_mag;
  assign r_mag  = div0_o ? '0 : a_mag % b_mag;
  assign quo_o  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_o  = a_neg ? -r_mag : r_mag;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div controller with HI/LO registers and pipeline stall generation.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_mden,
  output logic        busy,
  output logic        stall,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
  mdu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, a_q, b_q;
  logic          sgn_q, is_mul, is_div, div0;
  logic [63:0]   prod;
  logic [31:0]   quo, rem;
  assign is_mul = md_op == MD_MULT || md_op == MD_MULTU;
  assign is_div = md_op == MD_DIV || md_op == MD_DIVU;
  mdu_arith u_arith (
    .sgn_i  (sgn_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .prod_o (prod),
    .quo_o  (quo),
    .rem_o  (rem),
    .div0_o (div0)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
    end else case (state_q)
      S_MUL, S_DIV: begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_q <= S_IDLE;
          if (state_q == S_MUL) {hi_q, lo_q} <= prod;
          else if (!div0) {hi_q, lo_q} <= {rem, quo};
        end
      end
      default: if (start) begin
        if (is_mul || is_div) begin
          a_q     <= rs_data;
          b_q     <= rt_data;
          sgn_q   <= md_op == MD_MULT || md_op == MD_DIV;
          cnt_q   <= is_mul ? MC : DC;
          state_q <= is_mul ? S_MUL : S_DIV;
        end
        if (md_op == MD_MTHI) hi_q <= rs_data;
        if (md_op == MD_MTLO) lo_q <= rs_data;
      end
    endcase
  assign busy     = state_q != S_IDLE;
  // Reset gates stall so a decode-time mult/div request cannot stall while reset is held.
  assign stall    = reset & d_mden & (busy | (start & (is_mul | is_div)));
  assign md_rdata = md_op == MD_MFHI ? hi_q : md_op == MD_MFLO ? lo_q : '0;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl with hand-computed HI/LO, busy and stall timing.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, d_mden = 1'b0;
  logic [3:0]  md_op = '0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        busy, stall;
  logic [31:0] md_rdata, hi, lo;
  int          checks = 0, failures = 0;
  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .d_mden   (d_mden),
    .busy     (busy),
    .stall    (stall),
    .md_rdata (md_rdata),
    .hi       (hi),
    .lo       (lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Issue at the current negedge (cycle n), then expect busy/stall for n cycles and results after.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; d_mden = 1'b1;
    #1 chk({tag, "_stall_issue"}, stall, 1);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk); start = 1'b0; md_op = MD_MFHI; #1;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_stall"}, stall, 1);
    end
    @(negedge clk); #1;
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_stall_done"}, stall, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_rdata"}, md_rdata, eh);
  endtask
  task automatic simple(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; md_op = op; rs_data = a; d_mden = 1'b0;
    @(negedge clk); start = 1'b0; md_op = MD_NONE; #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask
  initial begin
    start = 1'b1; md_op = MD_MULT; d_mden = 1'b1; rs_data = 32'h5; rt_data = 32'h7;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    md_op = MD_MFHI; #1;
    chk("rst_rdata", md_rdata, 0);
    start = 1'b0; md_op = MD_NONE; d_mden = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    simple("mthi", MD_MTHI, 32'h12345678, 32'h12345678, 32'h0);
    simple("mtlo", MD_MTLO, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D);
    md_op = MD_MFLO; #1 chk("mflo_rdata", md_rdata, 32'hCAFEF00D);
    md_op = MD_MTHI; #1 chk("mthi_rdata", md_rdata, 0);
    simple("op0", MD_NONE, 32'h1, 32'h12345678, 32'hCAFEF00D);
    simple("op9", 4'd9, 32'h1, 32'h12345678, 32'hCAFEF00D);
    run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", MD_DIVU, 32'h7, 32'h0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divmin", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    // mult 3*4 with a divu and an mthi issued while busy; both must be ignored.
    start = 1'b1; md_op = MD_MULT; rs_data = 32'd3; rt_data = 32'd4; d_mden = 1'b0;
    @(negedge clk); md_op = MD_DIVU; rs_data = 32'd100; rt_data = 32'd3; #1;
    chk("ign_busy1", busy, 1);
    @(negedge clk); md_op = MD_MTHI; rs_data = 32'hDEADBEEF; #1;
    chk("ign_busy2", busy, 1);
    @(negedge clk); start = 1'b0; md_op = MD_NONE; #1;
    chk("ign_hi_held", hi, 32'd2);
    @(negedge clk); @(negedge clk); #1;
    chk("ign_busy5", busy, 1);
    @(negedge clk); #1;
    chk("ign_busy_done", busy, 0);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);
    // div aborted by reset in its third busy cycle.
    start = 1'b1; md_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7; d_mden = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); start = 1'b0; md_op = MD_MFLO; #1;
      chk("abort_busy", busy, 1);
    end
    reset = 1'b0; #1;
    chk("abort_busy_rst", busy, 0);
    chk("abort_stall_rst", stall, 0);
    chk("abort_hi_rst", hi, 0);
    chk("abort_lo_rst", lo, 0);
    @(negedge clk); reset = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("abort_busy_after", busy, 0);
    chk("abort_hi_after", hi, 0);
    chk("abort_lo_after", lo, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
